// File: rtl/mem_miss_arb_pkg.sv
// Shared types and constants for the cache-miss arbiter.
// Widths, packed request layout, FSM state encoding and cache-id encodings.
package mem_miss_arb_pkg;

  localparam int ADDR_W = 20;
  localparam int LINE_W = 128;
  localparam int INFO_W = ADDR_W + 1 + LINE_W;

  // {addr[148:129], is_store[128], data[127:0]}
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              is_store;
    logic [LINE_W-1:0] data;
  } miss_req_info_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_RESPOND  = 2'd3
  } arb_state_e;

  localparam logic CACHE_ID_DCACHE = 1'b1;
  localparam logic CACHE_ID_ICACHE = 1'b0;

endpackage

// File: rtl/miss_req_slot.sv
// One pending miss request per cache: valid/info holding register.
// A set in the same cycle as a clear wins; a set to a held slot is dropped and flagged.
module miss_req_slot
  import mem_miss_arb_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  input  logic           set,
  input  logic           clr,
  input  miss_req_info_t info,
  output logic           valid,
  output miss_req_info_t info_q,
  output logic           overflow
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid  <= 1'b0;
      info_q <= '0;
    end else if (set && (!valid || clr)) begin
      valid  <= 1'b1;
      info_q <= info;
    end else if (clr) begin
      valid  <= 1'b0;
    end
  end

  assign overflow = set & valid & ~clr;

endmodule

// File: rtl/mem_miss_arbiter.sv
// Arbitrates icache/dcache line misses onto one memory port and routes responses back.
// Define MEM_MISS_ARB_ROUND_ROBIN_EN for round-robin arbitration (default: dcache priority).
//
// state       | meaning
// ST_IDLE     | waiting for a valid slot; grants one and latches its request
// ST_ISSUE    | mem_req_valid held with stable fields until mem_req_ready
// ST_WAIT_RSP | waiting for mem_rsp_valid (read data or write ack)
// ST_RESPOND  | rsp_valid_miss high for one cycle; granted slot clears
module mem_miss_arbiter
  import mem_miss_arb_pkg::*;
#(
  parameter int unsigned MEM_LINES = 320
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dcache_req_valid_miss,
  input  logic [INFO_W-1:0] dcache_req_info_miss,
  input  logic              icache_req_valid_miss,
  input  logic [INFO_W-1:0] icache_req_info_miss,
  output logic              rsp_valid_miss,
  output logic              rsp_cache_id,
  output logic [LINE_W-1:0] rsp_data_miss,
  output logic              rsp_bus_error,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_we,
  output logic [LINE_W-1:0] mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [LINE_W-1:0] mem_rsp_data,
  output logic              overflow_o
);

  localparam logic [ADDR_W-1:0] MEM_LINES_A = ADDR_W'(MEM_LINES);

  arb_state_e     state;
  logic           grant_id;
  logic           work_store;
  miss_req_info_t d_info, i_info, d_q, i_q, grant_info;
  logic           d_valid, i_valid, d_ovf, i_ovf, d_clr, i_clr;
  logic           pick_d, any_valid, addr_err;

  assign d_info = dcache_req_info_miss;
  assign i_info = icache_req_info_miss;

  assign d_clr = (state == ST_RESPOND) && (grant_id == CACHE_ID_DCACHE);
  assign i_clr = (state == ST_RESPOND) && (grant_id == CACHE_ID_ICACHE);

  miss_req_slot u_dslot (
    .clock    (clock),
    .reset    (reset),
    .set      (dcache_req_valid_miss),
    .clr      (d_clr),
    .info     (d_info),
    .valid    (d_valid),
    .info_q   (d_q),
    .overflow (d_ovf)
  );

  miss_req_slot u_islot (
    .clock    (clock),
    .reset    (reset),
    .set      (icache_req_valid_miss),
    .clr      (i_clr),
    .info     (i_info),
    .valid    (i_valid),
    .info_q   (i_q),
    .overflow (i_ovf)
  );

  assign any_valid = d_valid | i_valid;

`ifdef MEM_MISS_ARB_ROUND_ROBIN_EN
  logic last_grant;

  // On a tie the cache that was not granted last goes first.
  assign pick_d = d_valid && (!i_valid || (last_grant == CACHE_ID_ICACHE));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant <= CACHE_ID_ICACHE;
    end else if ((state == ST_IDLE) && any_valid) begin
      last_grant <= pick_d;
    end
  end
`else
  assign pick_d = d_valid;
`endif

  assign grant_info = pick_d ? d_q : i_q;
  assign addr_err   = (grant_info.addr >= MEM_LINES_A);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      grant_id       <= CACHE_ID_ICACHE;
      work_store     <= 1'b0;
      rsp_valid_miss <= 1'b0;
      rsp_cache_id   <= 1'b0;
      rsp_data_miss  <= '0;
      rsp_bus_error  <= 1'b0;
      mem_req_valid  <= 1'b0;
      mem_req_addr   <= '0;
      mem_req_we     <= 1'b0;
      mem_req_wdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_valid) begin
            grant_id   <= pick_d;
            work_store <= grant_info.is_store;
            if (addr_err) begin
              // Out-of-range lines never reach memory.
              state          <= ST_RESPOND;
              rsp_valid_miss <= 1'b1;
              rsp_cache_id   <= pick_d;
              rsp_data_miss  <= '0;
              rsp_bus_error  <= 1'b1;
            end else begin
              state         <= ST_ISSUE;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= grant_info.addr;
              mem_req_we    <= grant_info.is_store;
              mem_req_wdata <= grant_info.data;
            end
          end
        end
        ST_ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= ST_WAIT_RSP;
          end
        end
        ST_WAIT_RSP: begin
          if (mem_rsp_valid) begin
            state          <= ST_RESPOND;
            rsp_valid_miss <= 1'b1;
            rsp_cache_id   <= grant_id;
            rsp_data_miss  <= work_store ? '0 : mem_rsp_data;
            rsp_bus_error  <= 1'b0;
          end
        end
        ST_RESPOND: begin
          rsp_valid_miss <= 1'b0;
          rsp_data_miss  <= '0;
          rsp_bus_error  <= 1'b0;
          state          <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow_o <= 1'b0;
    end else if (d_ovf || i_ovf) begin
      overflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_miss_arbiter.sv
// Scoreboard bench for mem_miss_arbiter; models MEM_MISS_ARB_ROUND_ROBIN_EN when defined.
module tb_mem_miss_arbiter;
  import mem_miss_arb_pkg::*;

  typedef struct packed {
    logic              id;
    logic              err;
    logic [LINE_W-1:0] data;
  } exp_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [LINE_W-1:0] wdata;
  } req_t;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              dcache_req_valid_miss = 1'b0;
  logic [INFO_W-1:0] dcache_req_info_miss = '0;
  logic              icache_req_valid_miss = 1'b0;
  logic [INFO_W-1:0] icache_req_info_miss = '0;
  logic              rsp_valid_miss, rsp_cache_id, rsp_bus_error;
  logic [LINE_W-1:0] rsp_data_miss;
  logic              mem_req_valid, mem_req_we;
  logic              mem_req_ready = 1'b1;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [LINE_W-1:0] mem_req_wdata;
  logic              mem_rsp_valid = 1'b0;
  logic [LINE_W-1:0] mem_rsp_data = '0;
  logic              overflow_o;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  req_t req_q[$];
  logic tb_last = CACHE_ID_ICACHE;
  bit   hold_rsp = 1'b0;
  bit   stray = 1'b0;

  mem_miss_arbiter dut (
    .clock                 (clock),
    .reset                 (reset),
    .dcache_req_valid_miss (dcache_req_valid_miss),
    .dcache_req_info_miss  (dcache_req_info_miss),
    .icache_req_valid_miss (icache_req_valid_miss),
    .icache_req_info_miss  (icache_req_info_miss),
    .rsp_valid_miss        (rsp_valid_miss),
    .rsp_cache_id          (rsp_cache_id),
    .rsp_data_miss         (rsp_data_miss),
    .rsp_bus_error         (rsp_bus_error),
    .mem_req_valid         (mem_req_valid),
    .mem_req_ready         (mem_req_ready),
    .mem_req_addr          (mem_req_addr),
    .mem_req_we            (mem_req_we),
    .mem_req_wdata         (mem_req_wdata),
    .mem_rsp_valid         (mem_rsp_valid),
    .mem_rsp_data          (mem_rsp_data),
    .overflow_o            (overflow_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] mem_line(input logic [ADDR_W-1:0] a);
    if (a == 20'h10) return {16{8'hA5}};
    return {4{12'h5A5, a}};
  endfunction

  function automatic logic [INFO_W-1:0] mk(input logic [ADDR_W-1:0] a, input logic st,
                                          input logic [LINE_W-1:0] wd);
    return {a, st, wd};
  endfunction

  task automatic push_exp(input logic id, input logic [ADDR_W-1:0] a, input logic st,
                          input logic [LINE_W-1:0] wd);
    exp_t e;
    req_t r;
    e.id   = id;
    e.err  = (a >= 20'd320);
    e.data = (st || e.err) ? '0 : mem_line(a);
    exp_q.push_back(e);
    if (!e.err) begin
      r.addr  = a;
      r.we    = st;
      r.wdata = wd;
      req_q.push_back(r);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_pulses;
    dcache_req_valid_miss = 1'b0;
    icache_req_valid_miss = 1'b0;
  endtask

  // Cycle count from the request pulse (cycle 0) to rsp_valid_miss.
  task automatic wait_rsp(input int exp_lat, input string tag);
    int lat = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n == 1) clear_pulses();
      if (rsp_valid_miss) begin
        lat = n;
        break;
      end
    end
    chk(tag, 128'(lat), 128'(exp_lat));
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 60; n++) begin
      tick();
      if (exp_q.size() == 0) break;
    end
    chk(tag, 128'(exp_q.size()), 128'd0);
    tick();
  endtask

  // Response monitor / scoreboard and request-channel stability check.
  logic              prev_v = 1'b0, prev_r = 1'b0, prev_we = 1'b0;
  logic [ADDR_W-1:0] prev_a = '0;
  logic [LINE_W-1:0] prev_wd = '0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_v = 1'b0;
      end else begin
        if (rsp_valid_miss) begin
          if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 128'(rsp_valid_miss), 128'd0);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_id", 128'(rsp_cache_id), 128'(e.id));
            chk("rsp_data", rsp_data_miss, e.data);
            chk("rsp_err", 128'(rsp_bus_error), 128'(e.err));
            tb_last = e.id;
          end
        end else begin
          chk("idle_data", rsp_data_miss, 128'd0);
          chk("idle_err", 128'(rsp_bus_error), 128'd0);
        end
        if (prev_v && !prev_r) begin
          chk("hold_valid", 128'(mem_req_valid), 128'd1);
          chk("hold_addr", 128'(mem_req_addr), 128'(prev_a));
          chk("hold_we", 128'(mem_req_we), 128'(prev_we));
          chk("hold_wdata", mem_req_wdata, prev_wd);
        end
        prev_v  = mem_req_valid;
        prev_r  = mem_req_ready;
        prev_a  = mem_req_addr;
        prev_we = mem_req_we;
        prev_wd = mem_req_wdata;
      end
    end
  end

  // Memory model: completes one cycle after the request handshake.
  initial begin
    bit                hs;
    logic [ADDR_W-1:0] a;
    logic              we;
    logic [LINE_W-1:0] wd;
    req_t              r;
    forever begin
      @(negedge clock);
      hs = mem_req_valid && mem_req_ready && !reset;
      a  = mem_req_addr;
      we = mem_req_we;
      wd = mem_req_wdata;
      @(posedge clock);
      #1;
      if (hs) begin
        if (req_q.size() == 0) begin
          chk("mem_req_unexpected", 128'(hs), 128'd0);
        end else begin
          r = req_q.pop_front();
          chk("mem_addr", 128'(a), 128'(r.addr));
          chk("mem_we", 128'(we), 128'(r.we));
          if (r.we) chk("mem_wdata", wd, r.wdata);
        end
        mem_rsp_valid = !hold_rsp;
        mem_rsp_data  = we ? {4{$urandom()}} : mem_line(a);
      end else begin
        mem_rsp_valid = stray;
        mem_rsp_data  = {4{$urandom()}};
      end
    end
  end

  initial begin
    logic first;

    repeat (3) @(posedge clock);
    #2;
    chk("rst_rsp_valid", 128'(rsp_valid_miss), 128'd0);
    chk("rst_mem_valid", 128'(mem_req_valid), 128'd0);
    chk("rst_overflow", 128'(overflow_o), 128'd0);
    @(negedge clock);
    reset = 1'b0;
    tick();

    // Icache read, minimum latency
    icache_req_valid_miss = 1'b1;
    icache_req_info_miss  = mk(20'h10, 1'b0, '0);
    push_exp(CACHE_ID_ICACHE, 20'h10, 1'b0, '0);
    wait_rsp(4, "lat_icache_read");
    tick();

    // Dcache store, then reload the slot in the same cycle it clears
    dcache_req_valid_miss = 1'b1;
    dcache_req_info_miss  = mk(20'd5, 1'b1, 128'h1234);
    push_exp(CACHE_ID_DCACHE, 20'd5, 1'b1, 128'h1234);
    wait_rsp(4, "lat_dcache_store");
    dcache_req_valid_miss = 1'b1;
    dcache_req_info_miss  = mk(20'd3, 1'b0, '0);
    push_exp(CACHE_ID_DCACHE, 20'd3, 1'b0, '0);
    tick();
    clear_pulses();
    drain("drain_reload");
    chk("no_ovf_on_reload", 128'(overflow_o), 128'd0);

    // Simultaneous requests, twice
    for (int r = 0; r < 2; r++) begin
`ifdef MEM_MISS_ARB_ROUND_ROBIN_EN
      first = (tb_last == CACHE_ID_ICACHE) ? CACHE_ID_DCACHE : CACHE_ID_ICACHE;
`else
      first = CACHE_ID_DCACHE;
`endif
      if (first == CACHE_ID_DCACHE) begin
        push_exp(CACHE_ID_DCACHE, 20'h31, 1'b0, '0);
        push_exp(CACHE_ID_ICACHE, 20'h30, 1'b0, '0);
      end else begin
        push_exp(CACHE_ID_ICACHE, 20'h30, 1'b0, '0);
        push_exp(CACHE_ID_DCACHE, 20'h31, 1'b0, '0);
      end
      dcache_req_valid_miss = 1'b1;
      dcache_req_info_miss  = mk(20'h31, 1'b0, '0);
      icache_req_valid_miss = 1'b1;
      icache_req_info_miss  = mk(20'h30, 1'b0, '0);
      tick();
      clear_pulses();
      drain("drain_tie");
    end

    // Address boundary
    dcache_req_valid_miss = 1'b1;
    dcache_req_info_miss  = mk(20'd320, 1'b0, '0);
    push_exp(CACHE_ID_DCACHE, 20'd320, 1'b0, '0);
    wait_rsp(2, "lat_bus_error");
    tick();
    dcache_req_valid_miss = 1'b1;
    dcache_req_info_miss  = mk(20'd319, 1'b0, '0);
    push_exp(CACHE_ID_DCACHE, 20'd319, 1'b0, '0);
    wait_rsp(4, "lat_last_line");
    tick();

    // Backpressure with stray completions during ISSUE
    mem_req_ready         = 1'b0;
    icache_req_valid_miss = 1'b1;
    icache_req_info_miss  = mk(20'h20, 1'b0, '0);
    push_exp(CACHE_ID_ICACHE, 20'h20, 1'b0, '0);
    tick();
    clear_pulses();
    for (int n = 0; n < 10; n++) begin
      if (mem_req_valid) break;
      tick();
    end
    chk("stall_valid_seen", 128'(mem_req_valid), 128'd1);
    for (int n = 0; n < 5; n++) begin
      stray = (n < 3);
      tick();
      chk("stall_valid", 128'(mem_req_valid), 128'd1);
      chk("stall_addr", 128'(mem_req_addr), 128'h20);
      chk("stall_no_rsp", 128'(rsp_valid_miss), 128'd0);
    end
    stray = 1'b0;
    tick();
    mem_req_ready = 1'b1;
    drain("drain_stall");

    // Overflow: second dcache request while the first is pending
    mem_req_ready         = 1'b0;
    dcache_req_valid_miss = 1'b1;
    dcache_req_info_miss  = mk(20'd7, 1'b0, '0);
    push_exp(CACHE_ID_DCACHE, 20'd7, 1'b0, '0);
    tick();
    dcache_req_info_miss = mk(20'd8, 1'b1, 128'hBAD);
    tick();
    clear_pulses();
    tick();
    chk("overflow_set", 128'(overflow_o), 128'd1);
    mem_req_ready = 1'b1;
    drain("drain_overflow");
    chk("overflow_sticky", 128'(overflow_o), 128'd1);

    // Reset while waiting for the memory completion
    hold_rsp              = 1'b1;
    icache_req_valid_miss = 1'b1;
    icache_req_info_miss  = mk(20'd9, 1'b1, 128'h55);
    push_exp(CACHE_ID_ICACHE, 20'd9, 1'b1, 128'h55);
    tick();
    clear_pulses();
    repeat (3) tick();
    chk("pre_rst_addr", 128'(mem_req_addr), 128'd9);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_addr", 128'(mem_req_addr), 128'd0);
    chk("mid_rst_we", 128'(mem_req_we), 128'd0);
    chk("mid_rst_wdata", mem_req_wdata, 128'd0);
    chk("mid_rst_valid", 128'(mem_req_valid), 128'd0);
    chk("mid_rst_rsp", 128'(rsp_valid_miss), 128'd0);
    chk("mid_rst_overflow", 128'(overflow_o), 128'd0);
    exp_q.delete();
    req_q.delete();
    tb_last  = CACHE_ID_ICACHE;
    hold_rsp = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    tick();

    // Recovery after reset
    dcache_req_valid_miss = 1'b1;
    dcache_req_info_miss  = mk(20'h44, 1'b0, '0);
    push_exp(CACHE_ID_DCACHE, 20'h44, 1'b0, '0);
    wait_rsp(4, "lat_after_reset");
    repeat (3) tick();
    chk("final_queue", 128'(exp_q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_miss_arbiter.md
# mem_miss_arbiter

Arbitrates cache-line miss requests from the icache and dcache of `core_top` onto a single main-memory port and routes each memory response back to the requesting cache. It sits between `core_top`'s miss interface (`*_req_valid_miss` / `*_req_info_miss` / `rsp_*`) and the backing line memory. It holds one pending request per cache and runs one memory transaction at a time over a valid/ready request channel. It flags out-of-range addresses as bus errors without touching memory.

## Interface
- `ADDR_W`, 20: line address width.
- `LINE_W`, 128: cache line width.
- `MEM_LINES`, 320: lines backed by memory; any address ≥ this value is a bus error.
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `dcache_req_valid_miss`  in  1  one-cycle dcache miss request pulse.
- `dcache_req_info_miss`  in  ADDR_W+1+LINE_W  {addr[148:129], is_store[128], wdata[127:0]}.
- `icache_req_valid_miss`  in  1  icache miss request pulse.
- `icache_req_info_miss`  in  ADDR_W+1+LINE_W  same layout as the dcache info.
- `rsp_valid_miss`  out  1  one-cycle response pulse; reset 0.
- `rsp_cache_id`  out  1  1 = dcache, 0 = icache; reset 0.
- `rsp_data_miss`  out  LINE_W  line data for loads, 0 for stores and errors; reset 0.
- `rsp_bus_error`  out  1  qualifies `rsp_valid_miss`; reset 0.
- `mem_req_valid`  out  1  memory request valid; reset 0.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_req_addr`  out  ADDR_W  request line address; reset 0.
- `mem_req_we`  out  1  1 = write line; reset 0.
- `mem_req_wdata`  out  LINE_W  write data; reset 0.
- `mem_rsp_valid`  in  1  memory completion (read data or write ack).
- `mem_rsp_data`  in  LINE_W  read data.
- `overflow_o`  out  1  sticky: a request arrived while that cache's slot was occupied; reset 0.

## Operation
- Two slots, one for dcache and one for icache, each holding {valid, info}.
  - A request pulse loads the slot on the next edge.
  - A request to an occupied slot is dropped and sets `overflow_o`.
  - If the slot is cleared and a new request arrives in the same cycle, the new request is loaded and no overflow is flagged.
- FSM states: IDLE, ISSUE, WAIT_RSP, RESPOND.
  - IDLE: if any slot is valid, grant one and latch its info into the working register.
    - Granted address ≥ MEM_LINES: go to RESPOND with error set.
    - Otherwise: go to ISSUE.
  - ISSUE: `mem_req_valid` = 1; addr, we and wdata are stable and come from registers. On `mem_req_ready`, go to WAIT_RSP.
  - WAIT_RSP: on `mem_rsp_valid`, capture `mem_rsp_data` (loads only) and go to RESPOND.
  - RESPOND: `rsp_valid_miss` = 1 for exactly one cycle with `rsp_cache_id`, data and error. The granted slot clears; return to IDLE.
- `mem_rsp_valid` is ignored in every state other than WAIT_RSP.
- Default arbitration is fixed priority: dcache wins when both slots are valid.
- All `rsp_*` and `mem_req_*` outputs are registered.
  - `rsp_data_miss` and `rsp_bus_error` are 0 whenever `rsp_valid_miss` = 0.

## Timing
- Request pulse at cycle 0 → slot valid at cycle 1 → ISSUE at cycle 2.
- With `mem_req_ready` high at cycle 2 and `mem_rsp_valid` at cycle 3, `rsp_valid_miss` is high at cycle 4. The minimum latency is therefore 4 cycles.
- Bus-error path: `rsp_valid_miss` is high at cycle 2; no memory request is issued.
- Back-to-back: after RESPOND, the other pending slot reaches ISSUE 2 cycles later (RESPOND → IDLE → ISSUE).
- `mem_req_valid` must not drop before `mem_req_ready`; addr, we and wdata are held constant while valid.
- Reset mid-transaction immediately clears the slots, the FSM, `overflow_o` and all outputs. The memory side must tolerate a withdrawn request.

## Configuration
- `MEM_MISS_ARB_ROUND_ROBIN_EN` defined: round-robin arbitration.
  - A 1-bit last-grant register is updated on every grant and reset to "icache", so dcache wins the first tie.
  - When both slots are valid, the cache not granted last wins.
- Macro undefined: fixed dcache priority and no last-grant register.

## Structure
- `mem_miss_arb_pkg` holds:
  - `ADDR_W` and `LINE_W` constants.
  - `miss_req_info_t`, a packed struct {addr, is_store, data} matching the 149-bit layout.
  - The FSM state enum.
  - The cache-id encodings `CACHE_ID_DCACHE = 1` and `CACHE_ID_ICACHE = 0`.
- Sub-module `miss_req_slot` is instantiated twice. It holds the valid/info register, set/clear priority and overflow detection.

## Test plan
- Icache read, addr 0x10, ready immediate, rsp_data 0xA5…A5 on the next cycle → `rsp_valid_miss` at cycle 4, id 0, data 0xA5…A5, error 0.
- Dcache store, addr 5, wdata 0x1234 → `mem_req_we` = 1, addr 5, wdata 0x1234; response data 0, id 1.
- Both caches request in the same cycle → dcache is served first, then icache.
  - With `MEM_MISS_ARB_ROUND_ROBIN_EN`: a repeated tie alternates the grant.
- Dcache read at addr 320 → `rsp_bus_error` = 1 at cycle 2, no `mem_req_valid`; addr 319 is served normally.
- `mem_req_ready` held low for 5 cycles → `mem_req_valid` and its fields stay stable; stray `mem_rsp_valid` in ISSUE is ignored.
- Second dcache request while the slot is pending → `overflow_o` = 1 and the first request completes intact. Reset asserted in WAIT_RSP → all outputs 0 immediately.
